uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, clock cycles per bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_LOG2, default 2, log2 of receive FIFO depth (depth 4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rd_en  input  1  pop head byte when rd_valid=1.
REQ-007 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-008 SHALL have port rd_data  output  8  FIFO head byte (first-word-fall-through).
REQ-009 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-010 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-011 SHALL have port frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all further logic uses the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rxs falling edge (previous 1, current 0) at cycle t -> START, bit counter loaded for CLK_DIV/2 (integer division).
REQ-015 START: at t+CLK_DIV/2 sample rxs; 0 -> DATA; 1 -> IDLE (glitch rejected, nothing pushed).
REQ-016 DATA: sample bit i (i=0..7, LSB first) at t+CLK_DIV/2+(i+1)*CLK_DIV into shift register; after bit 7 -> STOP.
REQ-017 STOP: sample at t+CLK_DIV/2+9*CLK_DIV; 1 -> push byte, IDLE; 0 -> set frame_err, discard byte, BREAK.
REQ-018 BREAK: remain until rxs=1, then IDLE; no start detection while in BREAK.
REQ-019 Pushed byte SHALL be visible on rd_data with rd_valid=1 on the cycle after the stop sample when FIFO was empty.
REQ-020 rd_en with rd_valid=1 SHALL advance head on next edge; rd_en with rd_valid=0 SHALL be ignored.
REQ-021 Push while full without simultaneous pop SHALL drop the new byte, keep FIFO contents, set overrun.
REQ-022 Push and pop in same cycle when full SHALL both be accepted; overrun unchanged.
REQ-023 Push and pop in same cycle when one entry SHALL leave rd_valid=1 with new byte at head.
REQ-024 FIFO pointers SHALL be FIFO_LOG2+1 bits wide, wrapping modulo 2^(FIFO_LOG2+1); full = MSBs differ, rest equal.
REQ-025 clr_err SHALL clear overrun and frame_err next edge; a same-cycle set event SHALL win over clr_err.
REQ-026 Bit-timing counter SHALL be 16 bits; no arithmetic overflow for any legal CLK_DIV.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, synchronizer flops 1, counters 0, FIFO empty, rd_valid 0, rd_data 0, overrun 0, frame_err 0.
REQ-028 rst mid-frame SHALL abandon the frame without pushing; after release, reception restarts only on a new falling edge.
REQ-029 FIFO storage array SHALL need no reset; rd_data SHALL read 0 while empty.

Structure
REQ-030 No shared package; CLK_DIV and FIFO_LOG2 are module parameters, state encodings are localparams.
REQ-031 FIFO SHALL be a sub-module sync_fifo (parameters WIDTH=8, LOG2; ports clk, rst, push, wdata, pop, rdata, empty, full).
REQ-032 Deserializer and FSM SHALL reside in uart_receiver itself.
REQ-033 Block SHALL map into the peripheral window with rd_en driven from a load decode; no bus logic inside this module.

Verification (CLK_DIV=8, FIFO_LOG2=2)
REQ-034 Send 0xA5 with 8-cycle bits -> rd_valid rises 1 cycle after stop sample, rd_data=0xA5, frame_err=0.
REQ-035 3-cycle low glitch on idle rx -> no push, FSM back in IDLE, rd_valid stays 0.
REQ-036 Send 5 bytes 0x01..0x05 without popping -> FIFO holds 0x01..0x04, overrun=1; pops yield 0x01..0x04 in order.
REQ-037 Send 0x3C with stop bit 0, then rx low 40 cycles, then 0x55 -> frame_err=1, only 0x55 received; clr_err clears frame_err.
REQ-038 Full FIFO, fifth byte stop sample coincident with rd_en -> 0x01 popped, 0x05 stored, overrun=0.
REQ-039 Assert rst during DATA of 0x77 -> all outputs 0, no byte after release; next 0x12 received correctly.

Source files
------------

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: a pushed word is on rdata the cycle after the push edge.
// A push while full is accepted only if a pop happens on the same edge; otherwise it is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << LOG2;

  logic [LOG2:0]      wr_ptr;
  logic [LOG2:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                   (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[LOG2-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling FSM, byte visible one cycle after stop sample.
// Bytes arriving while the FIFO is full and not being read are dropped and flagged as overrun.
module uart_receiver #(
  parameter int CLK_DIV   = 104,
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overrun,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [15:0] BIT_CNT  = 16'(CLK_DIV);
  localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2);

  logic        rx_meta;
  logic        rxs;
  logic        rxs_d;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick;
  logic        push;
  logic        ferr_set;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovr_set;

  // Synchronizer and edge-history flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign tick     = (cnt == 16'd1);
  assign push     = (state == STOP) && tick && rxs;
  assign ferr_set = (state == STOP) && tick && !rxs;
  assign pop      = rd_en && rd_valid;
  assign ovr_set  = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            cnt   <= HALF_CNT;
          end
        end
        START: begin
          if (tick) begin
            cnt     <= rxs ? 16'd0 : BIT_CNT;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= BIT_CNT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt   <= '0;
            state <= rxs ? IDLE : BREAK;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set event on the same edge as clr_err must win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (ovr_set)  overrun   <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rd_valid = !fifo_empty;
endmodule
